// File: rtl/video_defs.sv
// Shared video definitions: FSM encoding for the line prefetcher plus default geometry.
// Imported by the line fetcher and the rest of the video pipeline.
package video_defs;

    localparam int COLS_DEF   = 64;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 16;
    localparam int LINE_W     = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/video_line_buf.sv
// Ping-pong scanline buffer: 2*COLS words, bank select is the address MSB.
// One write port for the fetcher, one registered read port for display.
module video_line_buf #(
    parameter int COLS   = 64,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic                      wr_bank,
    input  logic [$clog2(COLS)-1:0]   wr_col,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_bank,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic [DATA_W-1:0]         rd_data
);

    logic [DATA_W-1:0] mem [0:2*COLS-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_col}] <= wr_data;
        end
        rd_data <= mem[{rd_bank, rd_col}];
    end

endmodule

// File: rtl/video_line_fetch.sv
// Scanline prefetcher: fills the back bank during line blank, serves the front bank to display.
// Optional VIDEO_FETCH_STATS_EN adds a saturating underrun counter output.
module video_line_fetch
    import video_defs::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [LINE_W-1:0]       i_line_idx,
    input  logic                    i_line_end,
    input  logic [$clog2(COLS)-1:0] i_column,
    output logic [DATA_W-1:0]       o_vdata,
    input  logic [ADDR_W-1:0]       i_base_addr,
    output logic                    o_mem_req,
    output logic [ADDR_W-1:0]       o_mem_addr,
    input  logic                    i_mem_ack,
    input  logic [DATA_W-1:0]       i_mem_data,
    output logic                    o_busy,
    output logic                    o_underrun
`ifdef VIDEO_FETCH_STATS_EN
    ,
    output logic [15:0]             o_underrun_cnt
`endif
);

    localparam int COL_W = $clog2(COLS);

    logic [1:0]              state;
    logic                    disp_bank;
    logic                    valid;
    logic                    vld_p1;
    logic [LINE_W-1:0]       line;
    logic [COL_W-1:0]        col;
    logic                    line_end_p1;
    logic                    rise;
    logic                    fetching;
    logic                    last_col;
    logic                    line_done;
    logic                    buf_we;
    logic [LINE_W+COL_W-1:0] line_col;
    logic [DATA_W-1:0]       rd_data;

    assign rise      = i_line_end & ~line_end_p1;
    assign fetching  = (state == ST_FETCH);
    assign last_col  = (col == COL_W'(COLS - 1));
    assign line_done = fetching & i_mem_ack & last_col;
    // A word acked together with an early rise belongs to a discarded line unless it completes it.
    assign buf_we    = i_reset_n & fetching & i_mem_ack & (~rise | last_col);
    assign line_col  = {line, col};

    assign o_mem_req  = fetching;
    assign o_busy     = fetching;
    assign o_mem_addr = i_base_addr + ADDR_W'(line_col);
    assign o_vdata    = vld_p1 ? rd_data : '0;

    // Stage p1: registered line-end for edge detection
    always_ff @(posedge i_clk) begin
        line_end_p1 <= i_line_end;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            disp_bank  <= 1'b0;
            valid      <= 1'b0;
            vld_p1     <= 1'b0;
            o_underrun <= 1'b0;
            line       <= '0;
            col        <= '0;
        end else begin
            o_underrun <= 1'b0;
            vld_p1     <= valid;
            if (rise) begin
                if (fetching && !line_done) begin
                    o_underrun <= 1'b1;
                end else if (state == ST_DONE || line_done) begin
                    disp_bank <= ~disp_bank;
                    valid     <= 1'b1;
                end
                line  <= i_line_idx + LINE_W'(1);
                col   <= '0;
                state <= ST_FETCH;
            end else if (fetching && i_mem_ack) begin
                col <= col + COL_W'(1);
                if (last_col) begin
                    state <= ST_DONE;
                end
            end
        end
    end

`ifdef VIDEO_FETCH_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_underrun_cnt <= '0;
        end else if (o_underrun && o_underrun_cnt != 16'hFFFF) begin
            o_underrun_cnt <= o_underrun_cnt + 16'd1;
        end
    end
`endif

    video_line_buf #(
        .COLS   (COLS),
        .DATA_W (DATA_W)
    ) u_line_buf (
        .clk     (i_clk),
        .we      (buf_we),
        .wr_bank (~disp_bank),
        .wr_col  (col),
        .wr_data (i_mem_data),
        .rd_bank (disp_bank),
        .rd_col  (i_column),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_video_line_fetch.sv
// Scoreboard bench for video_line_fetch: reference model of the fetch FSM and display bank.
// Build with VIDEO_FETCH_STATS_EN defined to also exercise the underrun counter.
module tb_video_line_fetch;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [7:0]  i_line_idx;
    logic        i_line_end;
    logic [5:0]  i_column;
    logic [31:0] o_vdata;
    logic [15:0] i_base_addr;
    logic        o_mem_req;
    logic [15:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic        o_busy;
    logic        o_underrun;
`ifdef VIDEO_FETCH_STATS_EN
    logic [15:0] o_underrun_cnt;
`endif

    always #5 i_clk = ~i_clk;

    video_line_fetch dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_line_idx  (i_line_idx),
        .i_line_end  (i_line_end),
        .i_column    (i_column),
        .o_vdata     (o_vdata),
        .i_base_addr (i_base_addr),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ack   (i_mem_ack),
        .i_mem_data  (i_mem_data),
        .o_busy      (o_busy),
        .o_underrun  (o_underrun)
`ifdef VIDEO_FETCH_STATS_EN
        ,
        .o_underrun_cnt (o_underrun_cnt)
`endif
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    // Reference model state
    int          m_state = 0;
    logic [7:0]  m_line  = 8'd0;
    int          m_col   = 0;
    logic        m_valid = 1'b0;
    logic        m_under = 1'b0;
    logic        m_le_q  = 1'b0;
    logic [15:0] m_cnt   = 16'd0;
    logic [31:0] m_disp [64];
    logic [31:0] m_buf  [64];
    logic [31:0] rdq [$];
    int          ack_period = 1;
    int          phase = 0;
    int          busy_cycles = 0;

    task automatic cycle();
        logic        rise;
        logic        ack;
        logic        done;
        logic [15:0] exp_addr;
        exp_addr = i_base_addr + 16'({m_line, 6'(m_col)});
        chk("busy", 32'(o_busy), 32'(m_state == 1));
        chk("req", 32'(o_mem_req), 32'(m_state == 1));
        chk("underrun", 32'(o_underrun), 32'(m_under));
        if (m_state == 1) chk("addr", 32'(o_mem_addr), 32'(exp_addr));
        if (rdq.size() > 0) chk("vdata", o_vdata, rdq.pop_front());
`ifdef VIDEO_FETCH_STATS_EN
        chk("ucnt", 32'(o_underrun_cnt), 32'(m_cnt));
`endif
        if (o_busy) busy_cycles++;

        ack = o_mem_req && (phase % ack_period == 0);
        phase++;
        i_mem_ack  = ack;
        i_mem_data = mem_word(o_mem_addr);
        rdq.push_back((i_reset_n && m_valid) ? m_disp[i_column] : 32'd0);

        rise   = i_line_end && !m_le_q;
        m_le_q = i_line_end;
        if (!i_reset_n) m_cnt = 16'd0;
        else if (m_under && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (!i_reset_n) begin
            m_state = 0; m_valid = 1'b0; m_under = 1'b0; m_line = 8'd0; m_col = 0;
        end else begin
            done    = (m_state == 1) && ack && (m_col == 63);
            m_under = 1'b0;
            if (m_state == 1 && ack && (!rise || done)) m_buf[m_col] = mem_word(exp_addr);
            if (rise) begin
                if (m_state == 1 && !done) m_under = 1'b1;
                else if (m_state == 2 || done) begin
                    m_disp  = m_buf;
                    m_valid = 1'b1;
                end
                m_line  = i_line_idx + 8'd1;
                m_col   = 0;
                m_state = 1;
            end else if (m_state == 1 && ack) begin
                if (m_col == 63) m_state = 2;
                m_col = (m_col + 1) % 64;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            i_column = 6'($urandom_range(0, 63));
            cycle();
        end
    endtask

    initial begin
        i_reset_n = 1'b0; i_line_idx = 8'd4; i_line_end = 1'b0; i_column = 6'd0;
        i_base_addr = 16'h1000; i_mem_ack = 1'b0; i_mem_data = 32'd0;
        @(negedge i_clk);
        run(3);
        i_reset_n = 1'b1;
        run(2);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_vdata", o_vdata, 32'd0);

        // Scenario 1: full fetch of line 5, ack every cycle
        i_line_end = 1'b1; busy_cycles = 0;
        cycle();
        chk("s1_addr0", 32'(o_mem_addr), 32'h1140);
        run(70);
        chk("s1_busy_cycles", 32'(busy_cycles), 32'd64);
        chk("s1_done_idle", 32'(o_busy), 32'd0);
        i_line_end = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_column = 6'(i * 7);
            cycle();
            chk("s2_pre_swap", o_vdata, 32'd0);
        end

        // Scenario 2: swap, then column 5 of line 5
        i_line_idx = 8'd5; i_line_end = 1'b1;
        cycle();
        i_line_end = 1'b0; i_column = 6'd5;
        cycle();
        chk("s2_col5", o_vdata, mem_word(16'h1145));
        run(70);

        // Scenario 3: slow memory, early rise -> underrun, display kept
        i_line_idx = 8'd9; i_line_end = 1'b1;
        cycle();
        ack_period = 3;
        i_line_end = 1'b0;
        run(59);
        i_line_idx = 8'd11; i_line_end = 1'b1;
        cycle();
        chk("s3_underrun", 32'(o_underrun), 32'd1);
        chk("s3_restart_addr", 32'(o_mem_addr), 32'h1300);
        i_line_end = 1'b0; i_column = 6'd5;
        cycle();
        chk("s3_pulse_end", 32'(o_underrun), 32'd0);
        chk("s3_keep", o_vdata, mem_word(16'h1185));

        // Scenario 4: ack of col 63 coincident with rise, then col 10 coincident with rise
        ack_period = 1;
        run(70);
        i_line_idx = 8'd20; i_line_end = 1'b1;
        cycle();
        i_line_end = 1'b0;
        run(63);
        i_line_idx = 8'd30; i_line_end = 1'b1;
        cycle();
        chk("s4_no_underrun", 32'(o_underrun), 32'd0);
        i_line_end = 1'b0; i_column = 6'd5;
        cycle();
        chk("s4_swap", o_vdata, mem_word(16'h1545));
        run(9);
        i_line_idx = 8'd40; i_line_end = 1'b1;
        cycle();
        chk("s4_underrun10", 32'(o_underrun), 32'd1);
        i_line_end = 1'b0; i_column = 6'd5;
        cycle();
        chk("s4_keep", o_vdata, mem_word(16'h1545));

        // Scenario 5: line index wrap, then reset mid-fetch
        run(70);
        i_line_idx = 8'd255; i_line_end = 1'b1;
        cycle();
        chk("s5_addr0", 32'(o_mem_addr), 32'h1000);
        i_line_end = 1'b0;
        run(70);
        i_line_idx = 8'd100; i_line_end = 1'b1;
        cycle();
        i_line_end = 1'b0; i_column = 6'd5;
        cycle();
        chk("s5_line0", o_vdata, mem_word(16'h1005));
        run(10);
        i_reset_n = 1'b0;
        cycle();
        chk("s5_rst_req", 32'(o_mem_req), 32'd0);
        i_reset_n = 1'b1;
        cycle();
        chk("s5_rst_vdata", o_vdata, 32'd0);

`ifdef VIDEO_FETCH_STATS_EN
        // Scenario 6: three underruns, then saturation
        i_line_end = 1'b1;
        cycle();
        for (int k = 0; k < 3; k++) begin
            i_line_end = 1'b0;
            run(3);
            i_line_end = 1'b1;
            cycle();
        end
        i_line_end = 1'b0;
        run(2);
        chk("s6_cnt3", 32'(o_underrun_cnt), 32'd3);
        force dut.o_underrun_cnt = 16'hFFFF;
        #1;
        release dut.o_underrun_cnt;
        m_cnt = 16'hFFFF;
        run(2);
        i_line_end = 1'b1;
        cycle();
        i_line_end = 1'b0;
        run(3);
        chk("s6_sat", 32'(o_underrun_cnt), 32'h0000FFFF);
`endif

        run(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
